// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte producers, with a tx_busy start timeout.
// Optional feature macro: UART_ARB_PRIORITY_EN (req[0] becomes a priority lane that bypasses the rotation).

module uart_tx_arbiter_checker #(
    parameter int NUM_REQ = 4
) (
    input logic               clk,
    input logic               rst,
    input logic [NUM_REQ-1:0] gnt,
    input logic               tx_start
);

    gnt_onehot_a : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

    gnt_with_start_a : assert property (@(posedge clk) disable iff (rst) ((|gnt) == tx_start));

endmodule

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] active_id,
    output logic                       arb_busy,
    output logic                       err_timeout
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(BUSY_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    state_e              state_q;
    logic [ID_W-1:0]     last_id_q;
    logic [TMR_W-1:0]    timer_q;
    logic [TMR_W-1:0]    timer_d;
    logic [NUM_REQ-1:0]  gnt_q;
    logic                tx_start_q;
    logic [7:0]          tx_data_q;
    logic [ID_W-1:0]     active_id_q;
    logic                arb_busy_q;
    logic                err_timeout_q;

    logic [ID_W-1:0]     scan_idx_s;
    logic [ID_W-1:0]     rr_win_s;
    logic                rr_found_s;
    logic                pri_hit_s;
    logic                req_any_s;
    logic [ID_W-1:0]     win_s;
    logic [7:0]          win_byte_s;
    logic [NUM_REQ-1:0]  win_onehot_s;

    // Rotating scan starting just after the last winner; first pending requester wins.
    always_comb begin
        rr_win_s   = last_id_q;
        rr_found_s = 1'b0;
        scan_idx_s = last_id_q;
        for (int i = 1; i <= NUM_REQ; i++) begin
            scan_idx_s = ID_W'((int'(last_id_q) + i) % NUM_REQ);
            if (!rr_found_s && req[scan_idx_s]) begin
                rr_win_s   = scan_idx_s;
                rr_found_s = 1'b1;
            end else begin
                rr_found_s = rr_found_s;
            end
        end
    end

    // Priority lane override; when it fires the rotation pointer is left alone.
    always_comb begin
`ifdef UART_ARB_PRIORITY_EN
        pri_hit_s = req[0];
`else
        pri_hit_s = 1'b0;
`endif
        req_any_s = rr_found_s | pri_hit_s;
        if (pri_hit_s) begin
            win_s = '0;
        end else begin
            win_s = rr_win_s;
        end
    end

    // Winner's byte and one-hot grant vector.
    always_comb begin
        win_byte_s   = 8'h00;
        win_onehot_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_s == ID_W'(i)) begin
                win_byte_s      = req_data[8*i +: 8];
                win_onehot_s[i] = 1'b1;
            end else begin
                win_onehot_s[i] = 1'b0;
            end
        end
    end

    // Incremented timer value; the timeout fires when this reaches BUSY_TIMEOUT-1,
    // which places err_timeout exactly BUSY_TIMEOUT cycles after tx_start.
    always_comb begin
        timer_d = timer_q + TMR_W'(1);
    end

    // Arbitration FSM with all outputs registered; pulses default low every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            last_id_q     <= ID_W'(NUM_REQ - 1);
            timer_q       <= '0;
            gnt_q         <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            active_id_q   <= '0;
            arb_busy_q    <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            gnt_q         <= '0;
            tx_start_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A foreign frame in flight blocks arbitration until it ends.
                    if (!tx_busy && req_any_s) begin
                        state_q     <= START;
                        tx_data_q   <= win_byte_s;
                        active_id_q <= win_s;
                        gnt_q       <= win_onehot_s;
                        tx_start_q  <= 1'b1;
                        arb_busy_q  <= 1'b1;
                        if (!pri_hit_s) begin
                            last_id_q <= win_s;
                        end else begin
                            last_id_q <= last_id_q;
                        end
                    end else begin
                        state_q    <= IDLE;
                        arb_busy_q <= 1'b0;
                    end
                end
                START: begin
                    state_q <= WAIT_BUSY;
                    timer_q <= '0;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else if (timer_d == TMR_W'(BUSY_TIMEOUT - 1)) begin
                        state_q       <= IDLE;
                        arb_busy_q    <= 1'b0;
                        err_timeout_q <= 1'b1;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_q    <= IDLE;
                        arb_busy_q <= 1'b0;
                    end else begin
                        state_q <= WAIT_DONE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    arb_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign active_id   = active_id_q;
    assign arb_busy    = arb_busy_q;
    assign err_timeout = err_timeout_q;

    uart_tx_arbiter_checker #(
        .NUM_REQ (NUM_REQ)
    ) u_checker (
        .clk      (clk),
        .rst      (rst),
        .gnt      (gnt_q),
        .tx_start (tx_start_q)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx stand-in that
// raises tx_busy for FRAME cycles after each accepted tx_start.

module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int BUSY_TIMEOUT = 16;
    localparam int FRAME        = 12;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NUM_REQ-1:0]  req = '0;
    logic [31:0]         req_data = 32'h0;
    logic [NUM_REQ-1:0]  gnt;
    logic                tx_start;
    logic [7:0]          tx_data;
    logic                tx_busy;
    logic [1:0]          active_id;
    logic                arb_busy;
    logic                err_timeout;

    logic                model_en = 1'b1;
    logic                force_busy = 1'b0;
    logic                model_busy;
    int                  busy_cnt;
    logic [7:0]          last_rx = 8'h00;
    int                  stab_err = 0;
    int                  viol = 0;

    int                  n_cmp = 0;
    int                  n_fail = 0;

    always #5 clk = ~clk;

    assign tx_busy = model_busy | force_busy;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .active_id   (active_id),
        .arb_busy    (arb_busy),
        .err_timeout (err_timeout)
    );

    // uart_tx stand-in: accepts tx_start, holds busy for FRAME cycles, checks tx_data stays put.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_busy <= 1'b0;
            busy_cnt   <= 0;
        end else if (model_busy) begin
            if (tx_data !== last_rx) stab_err <= stab_err + 1;
            if (busy_cnt == 1) model_busy <= 1'b0;
            else busy_cnt <= busy_cnt - 1;
        end else if (model_en && tx_start === 1'b1 && !force_busy) begin
            model_busy <= 1'b1;
            busy_cnt   <= FRAME;
            last_rx    <= tx_data;
        end
    end

    // Grant sanity every cycle: at most one bit, always together with tx_start.
    always @(negedge clk) begin
        if (!rst) begin
            if ($countones(gnt) > 1 || ((|gnt) !== tx_start)) viol <= viol + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_start(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (tx_start !== 1'b1 && lat < 200);
    endtask

    task automatic wait_idle();
        int cnt;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (arb_busy !== 1'b0 && cnt < 500);
        check("idle_reached", 32'(arb_busy), 32'd0);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          exp_id;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat;
        int cnt;
        int gap;
        logic any_start;
        logic [3:0] exp_gnt;

`ifdef UART_ARB_PRIORITY_EN
        vecs[0] = '{4'b0100, 32'h00A5_0000, 2, 8'hA5};
        vecs[1] = '{4'b1111, 32'h4433_2211, 0, 8'h11};
        vecs[2] = '{4'b1110, 32'h4433_2211, 3, 8'h44};
        vecs[3] = '{4'b1110, 32'h4433_2211, 1, 8'h22};
        vecs[4] = '{4'b1110, 32'h4433_2211, 2, 8'h33};
        vecs[5] = '{4'b1010, 32'h4433_2211, 3, 8'h44};
        vecs[6] = '{4'b0011, 32'h4433_2211, 0, 8'h11};
        vecs[7] = '{4'b0010, 32'h4433_2211, 1, 8'h22};
`else
        vecs[0] = '{4'b0100, 32'h00A5_0000, 2, 8'hA5};
        vecs[1] = '{4'b1111, 32'h4433_2211, 3, 8'h44};
        vecs[2] = '{4'b1111, 32'h4433_2211, 0, 8'h11};
        vecs[3] = '{4'b1010, 32'h4433_2211, 1, 8'h22};
        vecs[4] = '{4'b1010, 32'h4433_2211, 3, 8'h44};
        vecs[5] = '{4'b0011, 32'h4433_2211, 0, 8'h11};
        vecs[6] = '{4'b1000, 32'h4433_2211, 3, 8'h44};
        vecs[7] = '{4'b0001, 32'h4433_2211, 0, 8'h11};
`endif

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_active_id", 32'(active_id), 32'd0);
        check("rst_arb_busy", 32'(arb_busy), 32'd0);
        check("rst_err_timeout", 32'(err_timeout), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table: one frame per vector, requester drops req once granted
        for (int i = 0; i < 8; i++) begin
            req      = vecs[i].req;
            req_data = vecs[i].data;
            wait_start(lat);
            exp_gnt = 4'b0001 << vecs[i].exp_id;
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd1);
            check($sformatf("v%0d_gnt", i), 32'(gnt), 32'(exp_gnt));
            check($sformatf("v%0d_active_id", i), 32'(active_id), 32'(vecs[i].exp_id));
            check($sformatf("v%0d_tx_data", i), 32'(tx_data), 32'(vecs[i].exp_byte));
            req = '0;
            wait_idle();
            check($sformatf("v%0d_rx_byte", i), 32'(last_rx), 32'(vecs[i].exp_byte));
        end

        // Wrap: grant 3, then req[3] and req[1] held -> 1 then 3, two idle clocks between frames
        req      = 4'b1000;
        req_data = 32'h4433_2211;
        wait_start(lat);
        check("wrap_first_id", 32'(active_id), 32'd3);
        req = 4'b1010;
        cnt = 0;
        while (tx_busy !== 1'b1 && cnt < 50) begin @(negedge clk); cnt++; end
        while (tx_busy !== 1'b0 && cnt < 100) begin @(negedge clk); cnt++; end
        gap = 0;
        while (tx_start !== 1'b1 && gap < 50) begin gap++; @(negedge clk); end
        check("b2b_idle_gap", 32'(gap), 32'd2);
        check("wrap_second_id", 32'(active_id), 32'd1);
        check("wrap_second_gnt", 32'(gnt), 32'b0010);
        wait_start(lat);
        check("wrap_third_id", 32'(active_id), 32'd3);
        check("wrap_third_data", 32'(tx_data), 32'h44);
        req = '0;
        wait_idle();

        // Timeout: uart_tx disconnected, err_timeout BUSY_TIMEOUT cycles after tx_start
        model_en = 1'b0;
        req      = 4'b0001;
        req_data = 32'h0000_0077;
        wait_start(lat);
        check("to_gnt", 32'(gnt), 32'b0001);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (err_timeout !== 1'b1 && cnt < 100);
        check("to_delay", 32'(cnt), 32'(BUSY_TIMEOUT));
        check("to_arb_busy", 32'(arb_busy), 32'd0);
        @(negedge clk);
        check("to_pulse_width", 32'(err_timeout), 32'd0);
        check("to_rearb_start", 32'(tx_start), 32'd1);
        req = '0;
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (err_timeout !== 1'b1 && cnt < 100);
        check("to_second_err", 32'(err_timeout), 32'd1);
        model_en = 1'b1;
        wait_idle();

        // Foreign busy in IDLE blocks arbitration
        force_busy = 1'b1;
        req        = 4'b0100;
        req_data   = 32'h0033_0000;
        any_start  = 1'b0;
        repeat (4) begin @(negedge clk); any_start |= tx_start; end
        check("foreign_no_start", 32'(any_start), 32'd0);
        check("foreign_arb_busy", 32'(arb_busy), 32'd0);
        force_busy = 1'b0;
        wait_start(lat);
        check("foreign_release_lat", 32'(lat), 32'd1);
        check("foreign_release_id", 32'(active_id), 32'd2);
        req = '0;
        wait_idle();

        // Reset mid-frame clears outputs immediately, then a clean frame follows
        req      = 4'b0001;
        req_data = 32'h0000_003C;
        wait_start(lat);
        req = '0;
        cnt = 0;
        while (tx_busy !== 1'b1 && cnt < 50) begin @(negedge clk); cnt++; end
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_tx_data", 32'(tx_data), 32'd0);
        check("mid_rst_active_id", 32'(active_id), 32'd0);
        check("mid_rst_arb_busy", 32'(arb_busy), 32'd0);
        check("mid_rst_gnt_start", 32'({gnt, tx_start, err_timeout}), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        req      = 4'b0010;
        req_data = 32'h0000_5A00;
        wait_start(lat);
        check("post_rst_lat", 32'(lat), 32'd1);
        check("post_rst_id", 32'(active_id), 32'd1);
        check("post_rst_tx_data", 32'(tx_data), 32'h5A);
        req = '0;
        wait_idle();
        check("post_rst_rx", 32'(last_rx), 32'h5A);

        check("tx_data_stable", 32'(stab_err), 32'd0);
        check("gnt_onehot_with_start", 32'(viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
